// File: rtl/flags_ctx_ctrl_pkg.sv
// Shared definitions for the CCR flags context sequencer.
package flags_ctx_ctrl_pkg;

    // Width of one flags word {v,c,n,z}
    localparam int FLAG_W = 4;

    // Bit positions inside a flags word
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PUSH   = 2'd1,
        ST_VECTOR = 2'd2,
        ST_POP    = 2'd3
    } state_t;

endpackage

// File: rtl/flags_ctx_ctrl_flag_stack.sv
// LIFO of saved flag words; dout always shows the top entry (0 when empty).
module flags_ctx_ctrl_flag_stack
    import flags_ctx_ctrl_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int FLAG_W = flags_ctx_ctrl_pkg::FLAG_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [FLAG_W-1:0]          din,
    output logic [FLAG_W-1:0]          dout,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [FLAG_W-1:0] mem [DEPTH];
    logic [AW-1:0]     top_idx;

    assign top_idx = AW'(count - CW'(1));

    // Push/pop with saturating guards so the pointer never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && (count < FULL)) begin
            mem[count[AW-1:0]] <= din;
            count              <= count + CW'(1);
        end else if (pop && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    // Top-of-stack read
    always_comb begin
        dout = '0;
        if (count != '0) begin
            dout = mem[top_idx];
        end
    end

endmodule

// File: rtl/flags_ctx_ctrl.sv
// Context sequencer: saves CCR flags on interrupt entry, restores them on RTI.
//
//  state  | meaning
//  IDLE   | waiting for rti or an acceptable interrupt
//  PUSH   | save_flags strobe, live flags written to the stack
//  VECTOR | vec_req held until the vector fetch completes
//  POP    | restore_flags strobe, top of stack presented on restore_value
module flags_ctx_ctrl
    import flags_ctx_ctrl_pkg::*;
#(
    parameter int FLAG_W  = flags_ctx_ctrl_pkg::FLAG_W,
    parameter int DEPTH   = 4,
    parameter bit NEST_EN = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    irq_req,
    input  logic                    irq_en,
    input  logic                    rti,
    input  logic [FLAG_W-1:0]       flags_in,
    input  logic                    vec_ack,
    input  logic                    err_clr,
    output logic                    save_flags,
    output logic                    restore_flags,
    output logic [FLAG_W-1:0]       restore_value,
    output logic                    vec_req,
    output logic                    irq_ack,
    output logic                    stall,
    output logic [$clog2(DEPTH):0]  depth,
    output logic                    ovf_err,
    output logic                    unf_err
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    state_t            state, state_nx;
    logic [FLAG_W-1:0] top;
    logic              empty, full, irq_live, accept;
    logic              ovf_set, unf_set;

    assign empty = (depth == '0);
    assign full  = (depth == FULL);
    // The requester drops irq_req only after seeing irq_ack, so the ack
    // cycle must not count as a fresh request.
    assign irq_live = irq_req & irq_en & ~irq_ack;
    assign accept   = ~full & (NEST_EN | empty);
    assign ovf_set  = (state == ST_IDLE) & ~rti & irq_live & full;
    assign unf_set  = (state == ST_IDLE) & rti & empty;

    flags_ctx_ctrl_flag_stack #(
        .DEPTH  (DEPTH),
        .FLAG_W (FLAG_W)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (state == ST_PUSH),
        .pop   (state == ST_POP),
        .din   (flags_in),
        .dout  (top),
        .count (depth)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        state_nx      = state;
        save_flags    = 1'b0;
        restore_flags = 1'b0;
        restore_value = '0;
        vec_req       = 1'b0;
        stall         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rti && !empty) begin
                    state_nx = ST_POP;
                end else if (!rti && irq_live && accept) begin
                    state_nx = ST_PUSH;
                end
            end
            ST_PUSH: begin
                save_flags = 1'b1;
                stall      = 1'b1;
                state_nx   = ST_VECTOR;
            end
            ST_VECTOR: begin
                vec_req = 1'b1;
                stall   = 1'b1;
                if (vec_ack) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_POP: begin
                restore_flags = 1'b1;
                restore_value = top;
                stall         = 1'b1;
                state_nx      = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Acknowledge pulse one cycle after the vector fetch completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_ack <= 1'b0;
        end else begin
            irq_ack <= (state == ST_VECTOR) & vec_ack;
        end
    end

    // Sticky error flags; a clear wins over a same-cycle set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else if (err_clr) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            if (ovf_set) ovf_err <= 1'b1;
            if (unf_set) unf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_flags_ctx_ctrl.sv
// Bench for flags_ctx_ctrl: directed scenarios plus a random irq/rti mix
// checked against a queue model of the flag stack.
module tb_flags_ctx_ctrl;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       irq_req = 0, irq_en = 0, rti = 0, vec_ack = 0, err_clr = 0;
    logic [3:0] flags_in = '0;
    logic       save_flags, restore_flags, vec_req, irq_ack, stall, ovf_err, unf_err;
    logic [3:0] restore_value;
    logic [2:0] depth;

    logic       b_irq_req = 0, b_irq_en = 0, b_rti = 0, b_vec_ack = 0, b_err_clr = 0;
    logic [3:0] b_flags_in = '0;
    logic       b_save, b_restore, b_vec_req, b_irq_ack, b_stall, b_ovf, b_unf;
    logic [3:0] b_restore_value;
    logic [2:0] b_depth;

    flags_ctx_ctrl #(.DEPTH(DEPTH), .NEST_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .irq_req(irq_req), .irq_en(irq_en), .rti(rti),
        .flags_in(flags_in), .vec_ack(vec_ack), .err_clr(err_clr),
        .save_flags(save_flags), .restore_flags(restore_flags),
        .restore_value(restore_value), .vec_req(vec_req), .irq_ack(irq_ack),
        .stall(stall), .depth(depth), .ovf_err(ovf_err), .unf_err(unf_err)
    );

    flags_ctx_ctrl #(.DEPTH(DEPTH), .NEST_EN(1'b0)) dut_nonest (
        .clk(clk), .rst_n(rst_n), .irq_req(b_irq_req), .irq_en(b_irq_en), .rti(b_rti),
        .flags_in(b_flags_in), .vec_ack(b_vec_ack), .err_clr(b_err_clr),
        .save_flags(b_save), .restore_flags(b_restore),
        .restore_value(b_restore_value), .vec_req(b_vec_req), .irq_ack(b_irq_ack),
        .stall(b_stall), .depth(b_depth), .ovf_err(b_ovf), .unf_err(b_unf)
    );

    int checks = 0;
    int errors = 0;

    logic [3:0] model_q[$];
    bit         ovf_m = 0, unf_m = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_irq(input logic [3:0] f);
        int lat;
        irq_req = 1; irq_en = 1; flags_in = f;
        tick();
        if (model_q.size() < DEPTH) begin
            checks++;
            if (save_flags !== 1'b1 || stall !== 1'b1 || vec_req !== 1'b0 || restore_flags !== 1'b0) begin
                errors++;
                $display("FAIL irq_save: save=%b stall=%b vec_req=%b restore=%b, want 1 1 0 0",
                         save_flags, stall, vec_req, restore_flags);
            end
            tick();
            model_q.push_back(f);
            checks++;
            if (vec_req !== 1'b1 || save_flags !== 1'b0 || depth !== 3'(model_q.size())) begin
                errors++;
                $display("FAIL irq_vector: vec_req=%b save=%b depth=%0d, want 1 0 %0d",
                         vec_req, save_flags, depth, model_q.size());
            end
            lat = $urandom_range(0, 3);
            for (int n = 0; n < lat; n++) begin
                tick();
                checks++;
                if (vec_req !== 1'b1 || irq_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL vec_hold: vec_req=%b irq_ack=%b, want 1 0", vec_req, irq_ack);
                end
            end
            vec_ack = 1;
            tick();
            vec_ack = 0; irq_req = 0;
            checks++;
            if (irq_ack !== 1'b1 || vec_req !== 1'b0 || stall !== 1'b0) begin
                errors++;
                $display("FAIL irq_ack: irq_ack=%b vec_req=%b stall=%b, want 1 0 0", irq_ack, vec_req, stall);
            end
            tick();
            checks++;
            if (irq_ack !== 1'b0 || save_flags !== 1'b0) begin
                errors++;
                $display("FAIL irq_ack_pulse: irq_ack=%b save=%b, want 0 0", irq_ack, save_flags);
            end
        end else begin
            ovf_m = 1;
            checks++;
            if (save_flags !== 1'b0 || ovf_err !== 1'b1 || depth !== 3'(DEPTH)) begin
                errors++;
                $display("FAIL irq_ovf: save=%b ovf_err=%b depth=%0d, want 0 1 %0d",
                         save_flags, ovf_err, depth, DEPTH);
            end
            tick();
            checks++;
            if (save_flags !== 1'b0 || vec_req !== 1'b0) begin
                errors++;
                $display("FAIL irq_ovf_hold: save=%b vec_req=%b, want 0 0", save_flags, vec_req);
            end
            irq_req = 0;
            tick();
        end
    endtask

    task automatic do_rti();
        logic [3:0] exp;
        rti = 1;
        tick();
        rti = 0;
        if (model_q.size() == 0) begin
            unf_m = 1;
            checks++;
            if (restore_flags !== 1'b0 || unf_err !== 1'b1 || depth !== 3'd0) begin
                errors++;
                $display("FAIL rti_unf: restore=%b unf_err=%b depth=%0d, want 0 1 0",
                         restore_flags, unf_err, depth);
            end
            tick();
        end else begin
            exp = model_q.pop_back();
            checks++;
            if (restore_flags !== 1'b1 || restore_value !== exp || save_flags !== 1'b0 || stall !== 1'b1) begin
                errors++;
                $display("FAIL rti_restore: restore=%b value=%h save=%b stall=%b, want 1 %h 0 1",
                         restore_flags, restore_value, save_flags, stall, exp);
            end
            tick();
            checks++;
            if (restore_flags !== 1'b0 || restore_value !== 4'h0 || depth !== 3'(model_q.size())) begin
                errors++;
                $display("FAIL rti_after: restore=%b value=%h depth=%0d, want 0 0 %0d",
                         restore_flags, restore_value, depth, model_q.size());
            end
        end
    endtask

    task automatic do_clr();
        err_clr = 1;
        tick();
        err_clr = 0;
        ovf_m = 0; unf_m = 0;
        checks++;
        if (ovf_err !== 1'b0 || unf_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clr: ovf=%b unf=%b, want 0 0", ovf_err, unf_err);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        #1;
        checks++;
        if ({save_flags, restore_flags, restore_value, vec_req, irq_ack, stall, depth, ovf_err, unf_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: save=%b restore=%b val=%h vec=%b ack=%b stall=%b depth=%0d ovf=%b unf=%b, want all 0",
                     save_flags, restore_flags, restore_value, vec_req, irq_ack, stall, depth, ovf_err, unf_err);
        end
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset_mid_vector();
        do_irq(4'h6);
        irq_req = 1; irq_en = 1; flags_in = 4'h9;
        tick();
        tick();
        checks++;
        if (vec_req !== 1'b1 || depth !== 3'd2) begin
            errors++;
            $display("FAIL mid_vector_setup: vec_req=%b depth=%0d, want 1 2", vec_req, depth);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if (vec_req !== 1'b0 || stall !== 1'b0 || depth !== 3'd0 || save_flags !== 1'b0 || irq_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: vec_req=%b stall=%b depth=%0d save=%b ack=%b, want 0 0 0 0 0",
                     vec_req, stall, depth, save_flags, irq_ack);
        end
        irq_req = 0; irq_en = 0;
        @(negedge clk);
        rst_n = 1;
        model_q.delete();
        ovf_m = 0; unf_m = 0;
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++;
            if (save_flags !== 1'b0 || restore_flags !== 1'b0 || vec_req !== 1'b0 || irq_ack !== 1'b0 || depth !== 3'd0) begin
                errors++;
                $display("FAIL reset_release: save=%b restore=%b vec=%b ack=%b depth=%0d, want 0 0 0 0 0",
                         save_flags, restore_flags, vec_req, irq_ack, depth);
            end
        end
    endtask

    task automatic test_basic();
        do_irq(4'b1010);
        do_rti();
    endtask

    task automatic test_nesting();
        do_irq(4'h1);
        do_irq(4'h2);
        do_irq(4'h3);
        do_rti();
        do_rti();
        do_rti();
    endtask

    task automatic test_full_and_errors();
        for (int i = 0; i < DEPTH; i++) do_irq(4'(i + 8));
        do_irq(4'hF);
        do_clr();
        for (int i = 0; i < DEPTH; i++) do_rti();
        do_rti();
        do_clr();
        // clear beats a same-cycle underflow
        rti = 1; err_clr = 1;
        tick();
        rti = 0; err_clr = 0;
        checks++;
        if (unf_err !== 1'b0 || restore_flags !== 1'b0) begin
            errors++;
            $display("FAIL clr_beats_set: unf_err=%b restore=%b, want 0 0", unf_err, restore_flags);
        end
    endtask

    task automatic test_rti_irq_same_cycle();
        logic [3:0] exp;
        do_irq(4'h5);
        exp = model_q.pop_back();
        rti = 1; irq_req = 1; irq_en = 1; flags_in = 4'hC;
        tick();
        rti = 0;
        checks++;
        if (restore_flags !== 1'b1 || restore_value !== exp || save_flags !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_pop: restore=%b value=%h save=%b, want 1 %h 0",
                     restore_flags, restore_value, save_flags, exp);
        end
        tick();
        checks++;
        if (save_flags !== 1'b0 || restore_flags !== 1'b0 || depth !== 3'd0) begin
            errors++;
            $display("FAIL same_cycle_idle: save=%b restore=%b depth=%0d, want 0 0 0", save_flags, restore_flags, depth);
        end
        tick();
        checks++;
        if (save_flags !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_push: save=%b, want 1", save_flags);
        end
        tick();
        model_q.push_back(4'hC);
        vec_ack = 1;
        tick();
        vec_ack = 0; irq_req = 0;
        checks++;
        if (irq_ack !== 1'b1 || depth !== 3'd1) begin
            errors++;
            $display("FAIL same_cycle_ack: irq_ack=%b depth=%0d, want 1 1", irq_ack, depth);
        end
        tick();
        do_rti();
    endtask

    task automatic test_random();
        int op;
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 11);
            if (op < 5) begin
                do_irq(4'($urandom));
            end else if (op < 9) begin
                do_rti();
            end else if (op < 10) begin
                do_clr();
            end else begin
                irq_req = 1; irq_en = 0; flags_in = 4'($urandom);
                tick();
                tick();
                irq_req = 0;
                checks++;
                if (save_flags !== 1'b0 || vec_req !== 1'b0) begin
                    errors++;
                    $display("FAIL irq_disabled: save=%b vec_req=%b, want 0 0", save_flags, vec_req);
                end
            end
            checks++;
            if (depth !== 3'(model_q.size()) || ovf_err !== ovf_m || unf_err !== unf_m) begin
                errors++;
                $display("FAIL random_state it=%0d: depth=%0d ovf=%b unf=%b, want %0d %b %b",
                         it, depth, ovf_err, unf_err, model_q.size(), ovf_m, unf_m);
            end
        end
    endtask

    task automatic test_no_nest();
        b_irq_req = 1; b_irq_en = 1; b_flags_in = 4'h7;
        tick();
        checks++;
        if (b_save !== 1'b1) begin
            errors++;
            $display("FAIL nonest_first_save: save=%b, want 1", b_save);
        end
        tick();
        b_vec_ack = 1;
        tick();
        b_vec_ack = 0; b_irq_req = 0;
        tick();
        b_irq_req = 1; b_flags_in = 4'h4;
        for (int n = 0; n < 4; n++) begin
            tick();
            checks++;
            if (b_save !== 1'b0 || b_depth !== 3'd1 || b_ovf !== 1'b0) begin
                errors++;
                $display("FAIL nonest_held_off: save=%b depth=%0d ovf=%b, want 0 1 0", b_save, b_depth, b_ovf);
            end
        end
        b_rti = 1;
        tick();
        b_rti = 0;
        checks++;
        if (b_restore !== 1'b1 || b_restore_value !== 4'h7) begin
            errors++;
            $display("FAIL nonest_restore: restore=%b value=%h, want 1 7", b_restore, b_restore_value);
        end
        tick();
        tick();
        checks++;
        if (b_save !== 1'b1) begin
            errors++;
            $display("FAIL nonest_after_pop: save=%b, want 1", b_save);
        end
        tick();
        b_vec_ack = 1;
        tick();
        b_vec_ack = 0; b_irq_req = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nesting();
        test_full_and_errors();
        test_rti_irq_same_cycle();
        test_reset_mid_vector();
        test_random();
        test_no_nest();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
